// File: rtl/jmp_pred_unit.sv
// jmp_pred_unit: direct-mapped branch target buffer with a 2-bit direction
// counter per entry. Lookup is combinational on pc_now. Execute-stage branch
// resolution trains the table, and a mispredict produces a registered
// one-cycle flush_flag pulse.
// Optional build macro BPU_STATS_EN adds the saturating stat_upd/stat_mis counters.
module jmp_pred_unit #(
    parameter int          IDX_W    = 4,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_now,
    input  logic        lookup_en,
    output logic        jmp_pred,
    output logic [15:0] pc_jmp,
    input  logic        upd_en,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target,
    input  logic        upd_pred,
    input  logic [15:0] upd_pred_tgt,
`ifdef BPU_STATS_EN
    output logic [15:0] stat_upd,
    output logic [15:0] stat_mis,
`endif
    output logic        flush_flag
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 15 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [15:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX_W-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               lk_hit, up_hit, mis;

    assign lk_idx = pc_now[IDX_W:1];
    assign lk_tag = pc_now[15:IDX_W+1];
    assign up_idx = upd_pc[IDX_W:1];
    assign up_tag = upd_pc[15:IDX_W+1];

    // Lookup path: reads the registered table, so a same-cycle update is not yet visible
    always_comb begin
        lk_hit   = lookup_en & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
        jmp_pred = lk_hit & ctr_q[lk_idx][1];
        pc_jmp   = lk_hit ? tgt_q[lk_idx] : '0;
    end

    // Update-side hit test and mispredict detection
    always_comb begin
        up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
        mis    = upd_en & ((upd_pred != upd_taken) |
                           (upd_taken & upd_pred & (upd_pred_tgt != upd_target)));
    end

    // Table training: counter update on a hit, allocation on a taken miss
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                    tgt_q[up_idx] <= upd_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= upd_target;
                ctr_q[up_idx]   <= CTR_INIT;
            end
        end
    end

    // Flush pulse: one cycle after each mispredicting update, never held
    always_ff @(posedge clk) begin
        if (!rst_n) flush_flag <= 1'b0;
        else        flush_flag <= mis;
    end

`ifdef BPU_STATS_EN
    // Saturating event counters for updates and mispredicts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_upd <= '0;
            stat_mis <= '0;
        end else begin
            if (upd_en && stat_upd != '1) stat_upd <= stat_upd + 16'd1;
            if (mis && stat_mis != '1)    stat_mis <= stat_mis + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jmp_pred_unit.sv
// Bench for jmp_pred_unit: directed scenarios followed by random traffic,
// checked against a table-of-records reference model through a scoreboard queue.
module tb_jmp_pred_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_now;
    logic        lookup_en;
    logic        jmp_pred;
    logic [15:0] pc_jmp;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred;
    logic [15:0] upd_pred_tgt;
    logic        flush_flag;
`ifdef BPU_STATS_EN
    logic [15:0] stat_upd;
    logic [15:0] stat_mis;
`endif

    jmp_pred_unit #(.IDX_W(4), .CTR_INIT(2'b10)) dut (
        .clk(clk), .rst_n(rst_n), .pc_now(pc_now), .lookup_en(lookup_en),
        .jmp_pred(jmp_pred), .pc_jmp(pc_jmp), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred(upd_pred),
        .upd_pred_tgt(upd_pred_tgt),
`ifdef BPU_STATS_EN
        .stat_upd(stat_upd), .stat_mis(stat_mis),
`endif
        .flush_flag(flush_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          jp;
        logic [15:0] pj;
        bit          fl;
        int          su;
        int          sm;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: 16 entries, idx = (pc/2) mod 16, tag = pc/32
    bit          m_valid [16];
    int          m_tag   [16];
    logic [15:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_known = 0;
    bit          m_flush = 0;
    int          m_su = 0, m_sm = 0;

    function automatic int idx_of(input logic [15:0] pc);
        return (int'(pc) / 2) % 16;
    endfunction

    function automatic int tag_of(input logic [15:0] pc);
        return int'(pc) / 32;
    endfunction

    function automatic bit m_hit(input logic [15:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic step(input string nm, input bit rst, input bit le, input logic [15:0] pc,
                        input bit ue, input logic [15:0] upc, input bit tk,
                        input logic [15:0] tgt, input bit pr, input logic [15:0] prt);
        exp_t e;
        bit   mis;
        int   i;
        @(posedge clk);
        #1;
        rst_n = !rst; lookup_en = le; pc_now = pc;
        upd_en = ue; upd_pc = upc; upd_taken = tk; upd_target = tgt;
        upd_pred = pr; upd_pred_tgt = prt;
        if (m_known) begin
            e.name = nm;
            e.jp   = le && m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
            e.pj   = (le && m_hit(pc)) ? m_tgt[idx_of(pc)] : 16'h0000;
            e.fl   = m_flush;
            e.su   = m_su;
            e.sm   = m_sm;
            q.push_back(e);
        end
        mis = ue && ((pr != tk) || (tk && pr && (prt != tgt)));
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 16'h0000; m_ctr[k] = 1;
            end
            m_flush = 0; m_su = 0; m_sm = 0; m_known = 1;
        end else begin
            if (ue) begin
                i = idx_of(upc);
                if (m_hit(upc)) begin
                    if (tk) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = tgt;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (tk) begin
                    m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = tgt; m_ctr[i] = 2;
                end
                if (m_su < 65535) m_su++;
            end
            if (mis && m_sm < 65535) m_sm++;
            m_flush = mis;
        end
    endtask

    task automatic idle(input string nm, input logic [15:0] pc);
        step(nm, 0, 1, pc, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    endtask

    task automatic upd(input string nm, input logic [15:0] upc, input bit tk,
                       input logic [15:0] tgt, input bit pr, input logic [15:0] prt);
        step(nm, 0, 1, upc, 1, upc, tk, tgt, pr, prt);
    endtask

    // Monitor: outputs are valid every cycle once reset has been applied
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (jmp_pred !== e.jp) begin
                bad++;
                $display("FAIL %s jmp_pred: got %b want %b", e.name, jmp_pred, e.jp);
            end
            total++;
            if (pc_jmp !== e.pj) begin
                bad++;
                $display("FAIL %s pc_jmp: got %h want %h", e.name, pc_jmp, e.pj);
            end
            total++;
            if (flush_flag !== e.fl) begin
                bad++;
                $display("FAIL %s flush_flag: got %b want %b", e.name, flush_flag, e.fl);
            end
`ifdef BPU_STATS_EN
            total++;
            if (stat_upd !== 16'(e.su)) begin
                bad++;
                $display("FAIL %s stat_upd: got %0d want %0d", e.name, stat_upd, e.su);
            end
            total++;
            if (stat_mis !== 16'(e.sm)) begin
                bad++;
                $display("FAIL %s stat_mis: got %0d want %0d", e.name, stat_mis, e.sm);
            end
`endif
        end
    end

    initial begin
        logic [15:0] pool [4];
        logic [15:0] lpc, upc, tgt, prt;
        bit          tk, pr, ue, le, rs;
        int          guard;
        pool[0] = 16'h0100; pool[1] = 16'h0200; pool[2] = 16'h0300; pool[3] = 16'hFFFE;
        rst_n = 1'b0; lookup_en = 0; pc_now = '0; upd_en = 0; upd_pc = '0;
        upd_taken = 0; upd_target = '0; upd_pred = 0; upd_pred_tgt = '0;

        step("rst", 1, 1, 16'h0040, 0, 0, 0, 0, 0, 0);
        step("rst", 1, 1, 16'h0040, 1, 16'h0040, 1, 16'h0100, 0, 0);
        idle("post_rst", 16'h0040);
        idle("post_rst2", 16'h0040);

        upd("alloc", 16'h0040, 1, 16'h0100, 0, 16'h0000);
        idle("alloc_flush", 16'h0040);
        idle("alloc_noflush", 16'h0040);

        upd("nt1", 16'h0040, 0, 16'h0000, 1, 16'h0100);
        idle("nt1_chk", 16'h0040);
        upd("nt2", 16'h0040, 0, 16'h0000, 0, 16'h0000);
        idle("nt2_chk", 16'h0040);
        for (int k = 0; k < 4; k++) upd("sat_up", 16'h0040, 1, 16'h0100, 1, 16'h0100);
        idle("sat_chk", 16'h0040);
        upd("sat_dn1", 16'h0040, 0, 16'h0000, 1, 16'h0100);
        idle("sat_dn1_chk", 16'h0040);

        upd("alias", 16'h0440, 1, 16'h0300, 0, 16'h0000);
        idle("alias_old", 16'h0040);
        idle("alias_new", 16'h0440);
        step("lookup_off", 0, 0, 16'h0440, 0, 0, 0, 0, 0, 0);

        upd("realloc", 16'h0040, 1, 16'h0100, 0, 16'h0000);
        step("tgt_mis_same", 0, 1, 16'h0040, 1, 16'h0040, 1, 16'h0200, 1, 16'h0100);
        idle("tgt_mis_next", 16'h0040);
        idle("tgt_mis_after", 16'h0040);

        upd("pre_rst_mis", 16'h0040, 0, 16'h0000, 1, 16'h0200);
        step("mid_rst", 1, 1, 16'h0040, 1, 16'h0060, 1, 16'h0500, 0, 16'h0000);
        idle("mid_rst_chk", 16'h0040);
        idle("mid_rst_chk2", 16'h0060);
        upd("st1", 16'h0010, 1, 16'h0100, 0, 16'h0000);
        upd("st2", 16'h0010, 1, 16'h0100, 1, 16'h0100);
        upd("st3", 16'h0010, 1, 16'h0100, 1, 16'h0100);
        idle("st_chk", 16'h0010);
        // back-to-back mispredicts
        upd("b2b1", 16'h0010, 0, 16'h0000, 1, 16'h0100);
        upd("b2b2", 16'h0010, 1, 16'h0200, 0, 16'h0000);
        idle("b2b_chk", 16'h0010);

        for (int n = 0; n < 500; n++) begin
            upc = 16'(($urandom_range(0, 2) * 32) + ($urandom_range(0, 3) * 2));
            lpc = ($urandom_range(0, 9) < 3) ? upc
                : 16'(($urandom_range(0, 2) * 32) + ($urandom_range(0, 3) * 2));
            tk  = $urandom_range(0, 1);
            tgt = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) != 0) begin
                pr  = m_hit(upc) && (m_ctr[idx_of(upc)] >= 2);
                prt = m_hit(upc) ? m_tgt[idx_of(upc)] : 16'h0000;
            end else begin
                pr  = $urandom_range(0, 1);
                prt = pool[$urandom_range(0, 3)];
            end
            ue = $urandom_range(0, 1);
            le = ($urandom_range(0, 9) < 8);
            rs = ($urandom_range(0, 49) == 0);
            step("rand", rs, le, lpc, ue, upc, tk, tgt, pr, prt);
        end
        idle("final", 16'h0000);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jmp_pred_unit.md
Name: jmp_pred_unit

Overview:
- Branch prediction source for pc_gen; pc_gen consumes its outputs.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. Looked up combinationally with pc_now; drives jmp_pred and pc_jmp.
- Trained by the execute-stage branch resolution.
- Raises a registered, one-cycle flush_flag on a misprediction, which restarts fetch through pc_gen.

Parameters:
- IDX_W, 4, BTB index width; entry count = 2^IDX_W.
- CTR_INIT, 2'b10, counter value written when an entry is allocated (weakly taken).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pc_now  in  16  fetch PC being looked up
- lookup_en  in  1  lookup valid; pc_gen is not stalling (~wait_exe & ~wait_jmp)
- jmp_pred  out  1  predict taken for pc_now
- pc_jmp  out  16  predicted target
- upd_en  in  1  execute resolved a control-transfer instruction this cycle
- upd_pc  in  16  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  16  actual target, valid when upd_taken=1
- upd_pred  in  1  prediction carried down the pipe with this instruction
- upd_pred_tgt  in  16  predicted target carried down the pipe
- flush_flag  out  1  mispredict; pulse to pc_gen/pipeline

Behaviour:
Index and tag:
- idx = pc[IDX_W:1]; bit 0 is ignored because compressed instructions are 2-byte aligned.
- tag = pc[15:IDX_W+1].
- Per entry: valid, tag, target[15:0], ctr[1:0].

Lookup (combinational, zero latency):
- hit = lookup_en & valid[idx] & (tag[idx] == tag(pc_now)).
- jmp_pred = hit & ctr[idx][1].
- pc_jmp = hit ? target[idx] : 16'd0.
- lookup_en=0 forces jmp_pred=0 and pc_jmp=0.

Update (takes effect at the clk edge after upd_en=1):
- Entry hit (valid and tag match):
  - ctr increments, saturating at 2'b11, if upd_taken; decrements, saturating at 2'b00, if not taken.
  - If taken, target <= upd_target.
- Entry miss and upd_taken=1: allocate (overwrite) the entry. valid=1, tag from upd_pc, target=upd_target, ctr=CTR_INIT.
- Entry miss and upd_taken=0: no table change.

Mispredict:
- mis = upd_en & ((upd_pred != upd_taken) | (upd_taken & upd_pred & (upd_pred_tgt != upd_target))).
- flush_flag <= mis. It is registered, high exactly one cycle after the update cycle, and not held.
- Back-to-back mispredicts produce back-to-back flush_flag pulses.

Simultaneous events:
- Lookup and update to the same idx in one cycle: the lookup returns the pre-update contents. The new state is visible from the next cycle.
- flush_flag does not block table updates.

Reset (rst_n=0 at a clk edge):
- All valid=0, all ctr=2'b01, all target=0, all tag=0, flush_flag=0.
- Outputs therefore read jmp_pred=0 and pc_jmp=0.
- Reset mid-operation discards any pending flush.
- An update presented in the reset cycle is ignored.

Width rules:
- No PC arithmetic inside the block; all targets are stored as full 16 bits.

Optional Feature:
- Macro BPU_STATS_EN.
- When defined, adds outputs:
  - stat_upd  out  16: count of upd_en cycles.
  - stat_mis  out  16: count of mis cycles.
- Both counters saturate at 16'hFFFF, are cleared by rst_n, and increment one cycle after the event.
- When undefined: no ports, no counters; behaviour is otherwise identical.

Test Plan:
1. Reset, then lookup pc_now=16'h0040 with lookup_en=1 -> jmp_pred=0, pc_jmp=16'h0000. No flush_flag after reset.
2. Update upd_pc=16'h0040, taken, target=16'h0100, upd_pred=0 -> flush_flag=1 on the next cycle only. Then lookup 16'h0040 -> jmp_pred=1 (ctr=10), pc_jmp=16'h0100.
3. Same branch resolved not taken twice (upd_pred matching each prediction):
   - ctr 10 -> 01: the first update (upd_pred=1) flushes and jmp_pred becomes 0.
   - ctr 01 -> 00: the second update (upd_pred=0) raises no flush.
   - Four taken updates then saturate ctr at 11.
4. Alias: entry for 16'h0040 allocated, then taken update for 16'h0440 (IDX_W=4, same idx, different tag) -> lookup 16'h0040 misses (jmp_pred=0), lookup 16'h0440 hits with the new target.
5. Target mispredict: upd_pred=1, upd_taken=1, upd_pred_tgt=16'h0100, upd_target=16'h0200 -> flush_flag pulses; the next lookup returns pc_jmp=16'h0200. Same-cycle lookup of that idx returns 16'h0100.
6. rst_n low in the cycle after a mispredicting update -> flush_flag=0 and the table is cleared. With BPU_STATS_EN, stat_upd=stat_mis=0 after reset, and 3 updates with 1 mispredict give stat_upd=3, stat_mis=1.
